// File: rtl/uart_apb_master.sv
// Command-to-APB bridge: one register command in, one APB SETUP/ACCESS transfer, one response out.
// Define UART_APB_MASTER_TIMEOUT_EN to build the ACCESS-phase timeout counter and abort path.
module uart_apb_master #(
  parameter int APB_ADDR_WIDTH = 8,
  parameter int TIMEOUT        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_wr_i,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]               cmd_wdata_i,
  input  logic [3:0]                cmd_strb_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_addr_o,
  output logic                      apb_sel_o,
  output logic                      apb_en_o,
  output logic                      apb_wr_o,
  output logic [31:0]               apb_wdata_o,
  output logic [3:0]                apb_strb_o,
  input  logic [31:0]               apb_rdata_i,
  input  logic                      apb_ready_i,
  input  logic                      apb_err_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                    state, state_next;
  logic                      cmd_ready_next, rsp_valid_next, rsp_err_next, rsp_timeout_next;
  logic [31:0]               rsp_rdata_next, apb_wdata_next;
  logic [APB_ADDR_WIDTH-1:0] apb_addr_next;
  logic                      apb_sel_next, apb_en_next, apb_wr_next;
  logic [3:0]                apb_strb_next;
  logic                      done;

`ifdef UART_APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt, cnt_next;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    // NOTE: every next value defaults to its current value first, so no branch can infer a latch.
    state_next       = state;
    cmd_ready_next   = cmd_ready_o;
    rsp_valid_next   = rsp_valid_o;
    rsp_rdata_next   = rsp_rdata_o;
    rsp_err_next     = rsp_err_o;
    rsp_timeout_next = rsp_timeout_o;
    apb_addr_next    = apb_addr_o;
    apb_sel_next     = apb_sel_o;
    apb_en_next      = apb_en_o;
    apb_wr_next      = apb_wr_o;
    apb_wdata_next   = apb_wdata_o;
    apb_strb_next    = apb_strb_o;
    done             = 1'b0;
`ifdef UART_APB_MASTER_TIMEOUT_EN
    cnt_next         = cnt;
`endif

    unique case (state)
      IDLE: begin
        // cmd_ready is a register so it comes up one edge after reset is released.
        if (cmd_valid_i && cmd_ready_o) begin
          state_next     = SETUP;
          cmd_ready_next = 1'b0;
          apb_sel_next   = 1'b1;
          apb_en_next    = 1'b0;
          apb_wr_next    = cmd_wr_i;
          apb_addr_next  = cmd_addr_i;
          apb_wdata_next = cmd_wdata_i;
          apb_strb_next  = cmd_wr_i ? cmd_strb_i : 4'b0000;
        end else begin
          cmd_ready_next = 1'b1;
        end
      end
      SETUP: begin
        state_next  = ACCESS;
        apb_en_next = 1'b1;
`ifdef UART_APB_MASTER_TIMEOUT_EN
        cnt_next    = '0;
`endif
      end
      ACCESS: begin
        if (apb_ready_i) begin
          done             = 1'b1;
          rsp_rdata_next   = apb_wr_o ? 32'h0 : apb_rdata_i;
          rsp_err_next     = apb_err_i;
          rsp_timeout_next = 1'b0;
        end
`ifdef UART_APB_MASTER_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          done             = 1'b1;
          rsp_rdata_next   = 32'h0;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
`endif
        if (done) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          apb_sel_next   = 1'b0;
          apb_en_next    = 1'b0;
          apb_wr_next    = 1'b0;
          apb_addr_next  = '0;
          apb_wdata_next = 32'h0;
          apb_strb_next  = 4'b0000;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_next       = IDLE;
          cmd_ready_next   = 1'b1;
          rsp_valid_next   = 1'b0;
          rsp_rdata_next   = 32'h0;
          rsp_err_next     = 1'b0;
          rsp_timeout_next = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: data registers are reset too, because every output must read 0 while rst is high.
    if (rst) begin
      state         <= IDLE;
      cmd_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= 32'h0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      apb_addr_o    <= '0;
      apb_sel_o     <= 1'b0;
      apb_en_o      <= 1'b0;
      apb_wr_o      <= 1'b0;
      apb_wdata_o   <= 32'h0;
      apb_strb_o    <= 4'b0000;
`ifdef UART_APB_MASTER_TIMEOUT_EN
      cnt           <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all state updates together on the edge.
      state         <= state_next;
      cmd_ready_o   <= cmd_ready_next;
      rsp_valid_o   <= rsp_valid_next;
      rsp_rdata_o   <= rsp_rdata_next;
      rsp_err_o     <= rsp_err_next;
      rsp_timeout_o <= rsp_timeout_next;
      apb_addr_o    <= apb_addr_next;
      apb_sel_o     <= apb_sel_next;
      apb_en_o      <= apb_en_next;
      apb_wr_o      <= apb_wr_next;
      apb_wdata_o   <= apb_wdata_next;
      apb_strb_o    <= apb_strb_next;
`ifdef UART_APB_MASTER_TIMEOUT_EN
      cnt           <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed self-checking bench for uart_apb_master; the slave side is driven by hand per vector.
module tb_uart_apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_wr_i;
  logic [7:0]  cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
  logic [31:0] rsp_rdata_o;
  logic [7:0]  apb_addr_o;
  logic        apb_sel_o, apb_en_o, apb_wr_o;
  logic [31:0] apb_wdata_o, apb_rdata_i;
  logic [3:0]  apb_strb_o;
  logic        apb_ready_i, apb_err_i;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_apb_master #(.APB_ADDR_WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .apb_addr_o(apb_addr_o), .apb_sel_o(apb_sel_o), .apb_en_o(apb_en_o), .apb_wr_o(apb_wr_o),
    .apb_wdata_o(apb_wdata_o), .apb_strb_o(apb_strb_o), .apb_rdata_i(apb_rdata_i),
    .apb_ready_i(apb_ready_i), .apb_err_i(apb_err_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb);
    cmd_valid_i = 1'b1;
    cmd_wr_i    = wr;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_strb_i  = strb;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic consume(input string tag);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check({tag, "_rsp_valid_clr"}, 32'(rsp_valid_o), 32'h0);
    check({tag, "_cmd_ready_back"}, 32'(cmd_ready_o), 32'h1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_wr_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    cmd_strb_i = '0; rsp_ready_i = 1'b0; apb_rdata_i = '0; apb_ready_i = 1'b0; apb_err_i = 1'b0;
    tick(); tick();
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'h0);
    check("rst_sel_en", {apb_sel_o, apb_en_o}, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", 32'(cmd_ready_o), 32'h1);

    // Zero-wait write.
    apb_ready_i = 1'b1;
    issue(1'b1, 8'h04, 32'h0000_00A5, 4'b0001);
    check("wr_setup_sel_en", {apb_sel_o, apb_en_o}, 32'h2);
    check("wr_setup_addr", 32'(apb_addr_o), 32'h04);
    check("wr_setup_wr", 32'(apb_wr_o), 32'h1);
    check("wr_setup_wdata", apb_wdata_o, 32'h0000_00A5);
    check("wr_setup_strb", 32'(apb_strb_o), 32'h1);
    check("wr_setup_cmd_ready", 32'(cmd_ready_o), 32'h0);
    tick();
    check("wr_access_sel_en", {apb_sel_o, apb_en_o}, 32'h3);
    check("wr_access_wdata", apb_wdata_o, 32'h0000_00A5);
    tick();
    check("wr_rsp_valid", 32'(rsp_valid_o), 32'h1);
    check("wr_rsp_err_to", {rsp_err_o, rsp_timeout_o}, 32'h0);
    check("wr_rsp_rdata", rsp_rdata_o, 32'h0);
    check("wr_bus_released", {apb_sel_o, apb_en_o}, 32'h0);
    check("wr_wdata_clr", apb_wdata_o, 32'h0);
    apb_ready_i = 1'b0;
    consume("wr");

    // Read with three wait cycles.
    issue(1'b0, 8'h08, 32'hFFFF_FFFF, 4'b1111);
    check("rd_setup_strb", 32'(apb_strb_o), 32'h0);
    tick();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (apb_en_o) n++;
      check("rd_wait_strb", 32'(apb_strb_o), 32'h0);
      tick();
    end
    apb_ready_i = 1'b1;
    apb_rdata_i = 32'h1234_5678;
    if (apb_en_o) n++;
    tick();
    apb_ready_i = 1'b0;
    apb_rdata_i = 32'h0;
    check("rd_access_cycles", n, 32'd4);
    check("rd_rsp_rdata", rsp_rdata_o, 32'h1234_5678);
    check("rd_rsp_err", 32'(rsp_err_o), 32'h0);
    consume("rd");

    // Slave error on a read.
    apb_ready_i = 1'b1;
    apb_err_i   = 1'b1;
    issue(1'b0, 8'h0C, 32'h0, 4'b0000);
    tick();
    check("err_access_en", 32'(apb_en_o), 32'h1);
    tick();
    apb_ready_i = 1'b0;
    apb_err_i   = 1'b0;
    check("err_rsp_err_to", {rsp_err_o, rsp_timeout_o}, 32'h2);
    check("err_bus_released", {apb_sel_o, apb_en_o}, 32'h0);
    consume("err");

`ifdef UART_APB_MASTER_TIMEOUT_EN
    // Slave never ready: abort after exactly 16 ACCESS cycles.
    issue(1'b0, 8'h10, 32'h0, 4'b0000);
    tick();
    n = 0;
    while (apb_en_o && n < 40) begin
      n++;
      tick();
    end
    check("to_access_cycles", n, 32'd16);
    check("to_rsp_valid", 32'(rsp_valid_o), 32'h1);
    check("to_rsp_err_to", {rsp_err_o, rsp_timeout_o}, 32'h3);
    check("to_rsp_rdata", rsp_rdata_o, 32'h0);
    check("to_bus_released", {apb_sel_o, apb_en_o}, 32'h0);
    consume("to");

    // Ready in the 16th ACCESS cycle wins over the timeout.
    issue(1'b0, 8'h14, 32'h0, 4'b0000);
    tick();
    for (int i = 1; i <= 16; i++) begin
      if (i == 16) begin
        apb_ready_i = 1'b1;
        apb_rdata_i = 32'hCAFE_F00D;
      end
      check("to16_en_held", 32'(apb_en_o), 32'h1);
      tick();
    end
    apb_ready_i = 1'b0;
    apb_rdata_i = 32'h0;
    check("to16_rsp_err_to", {rsp_err_o, rsp_timeout_o}, 32'h0);
    check("to16_rsp_rdata", rsp_rdata_o, 32'hCAFE_F00D);
    consume("to16");
`else
    // Without the timeout the bridge waits as long as the slave needs.
    issue(1'b0, 8'h10, 32'h0, 4'b0000);
    tick();
    for (int i = 0; i < 20; i++) tick();
    check("wait_en_held", {apb_sel_o, apb_en_o}, 32'h3);
    apb_ready_i = 1'b1;
    apb_rdata_i = 32'hCAFE_F00D;
    tick();
    apb_ready_i = 1'b0;
    apb_rdata_i = 32'h0;
    check("wait_rsp_err_to", {rsp_err_o, rsp_timeout_o}, 32'h0);
    check("wait_rsp_rdata", rsp_rdata_o, 32'hCAFE_F00D);
    consume("wait");
`endif

    // Response back-pressure with cmd_valid held high throughout.
    apb_ready_i = 1'b1;
    apb_rdata_i = 32'hDEAD_BEEF;
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = 8'h18; cmd_strb_i = 4'b0000;
    tick(); tick(); tick();
    apb_rdata_i = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rsp_valid_o), 32'h1);
      check("bp_rsp_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
      check("bp_cmd_ready", 32'(cmd_ready_o), 32'h0);
      check("bp_no_setup", 32'(apb_sel_o), 32'h0);
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("bp_idle_cmd_ready", 32'(cmd_ready_o), 32'h1);
    check("bp_idle_sel", 32'(apb_sel_o), 32'h0);
    tick();
    cmd_valid_i = 1'b0;
    check("bp_next_setup", {apb_sel_o, apb_en_o}, 32'h2);
    tick(); tick();
    check("bp_next_rdata", rsp_rdata_o, 32'h5555_AAAA);
    apb_ready_i = 1'b0;
    apb_rdata_i = 32'h0;
    consume("bp");

    // Reset during ACCESS drops the transfer; the next command runs normally.
    issue(1'b1, 8'h20, 32'h0000_1111, 4'b0011);
    tick();
    check("rstm_access_en", 32'(apb_en_o), 32'h1);
    rst = 1'b1;
    tick();
    check("rstm_sel_en", {apb_sel_o, apb_en_o}, 32'h0);
    check("rstm_cmd_ready", 32'(cmd_ready_o), 32'h0);
    check("rstm_rsp_valid", 32'(rsp_valid_o), 32'h0);
    check("rstm_wdata_addr", {apb_wdata_o[23:0], apb_addr_o}, 32'h0);
    rst = 1'b0;
    tick();
    check("rstm_cmd_ready_up", 32'(cmd_ready_o), 32'h1);
    check("rstm_no_retry", 32'(apb_sel_o), 32'h0);
    apb_ready_i = 1'b1;
    issue(1'b1, 8'h24, 32'h0000_2222, 4'b1111);
    tick(); tick();
    apb_ready_i = 1'b0;
    check("rstm_new_rsp_valid", 32'(rsp_valid_o), 32'h1);
    check("rstm_new_rsp_err", {rsp_err_o, rsp_timeout_o}, 32'h0);
    consume("rstm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
